// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional perf counters (stall_cnt_o, bubble_cnt_o) enabled by PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int unsigned DATA_W     = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter bit          FLUSH_ZERO = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [31:0]       in_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [31:0]       out_pc_o,
  input  logic              flush_i,
  input  logic [31:0]       flush_pc_i,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o,
`endif
  output logic [1:0]        occupancy_o
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [31:0]       main_pc_q, main_pc_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [31:0]       skid_pc_q, skid_pc_d;

  logic push, pop;

  // in_ready depends only on a flop and flush, so no ready path crosses stages.
  assign in_ready_o = !skid_valid_q && !flush_i;
  assign push       = in_valid_i && in_ready_o;
  assign pop        = main_valid_q && out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_pc_d    = main_pc_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_pc_d    = skid_pc_q;

    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_pc_d    = flush_pc_i;
      if (FLUSH_ZERO) begin
        main_data_d = '0;
      end
    end else if (!main_valid_q || pop) begin
      // Main slot frees up: refill from skid first to keep FIFO order.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_pc_d    = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data_i;
        main_pc_d    = in_pc_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
      skid_pc_d    = in_pc_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_pc_q    <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_pc_q    <= RESET_PC;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_pc_q    <= main_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;
  assign out_pc_o    = main_pc_q;
  assign occupancy_o = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid_q && !out_ready_i) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (!main_valid_q || flush_i) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
